// File: rtl/axis_cropper.sv
// Crops a rectangular window out of an AXI4-Stream video stream; out-of-window pixels are consumed and dropped.
// Kept pixel reaches m_axis one cycle after acceptance; a two-entry skid with registered s_axis_tready absorbs output stalls.
module axis_cropper #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_WIDTH_BITS  = 12,
  parameter int C_HEIGHT_BITS = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  input  logic [C_WIDTH_BITS-1:0]  s_width,
  input  logic [C_HEIGHT_BITS-1:0] s_height,
  input  logic [C_WIDTH_BITS-1:0]  win_left,
  input  logic [C_WIDTH_BITS-1:0]  win_width,
  input  logic [C_HEIGHT_BITS-1:0] win_top,
  input  logic [C_HEIGHT_BITS-1:0] win_height,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [C_WIDTH_BITS-1:0]  m_width,
  output logic [C_HEIGHT_BITS-1:0] m_height
);

  localparam int WX = C_WIDTH_BITS + 1;
  localparam int HX = C_HEIGHT_BITS + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  typedef struct packed {
    logic [C_PIXEL_WIDTH-1:0] dat;
    logic                     user;
    logic                     last;
  } beat_t;

  logic [1:0]               state;
  logic [C_WIDTH_BITS-1:0]  col, cfg_sw, cfg_left, cfg_wid;
  logic [C_HEIGHT_BITS-1:0] row, cfg_sh, cfg_top, cfg_hgt;
  logic                     sof_pend;

  logic                     sk_vld;
  beat_t                    sk_beat, in_beat;

  logic                     accept, keep, pop, win_ok, in_win, live, beat_last;
  logic [C_WIDTH_BITS-1:0]  sel_sw, sel_left, sel_wid, cur_col, nxt_col;
  logic [C_HEIGHT_BITS-1:0] sel_sh, sel_top, sel_hgt, cur_row, nxt_row;
  logic [WX-1:0]            avail_w, effw, col_end;
  logic [HX-1:0]            avail_h, effh, row_end;
  logic [1:0]               occ, occ_nxt;

  // A tuser beat is judged against the live config it is about to latch, not the stale one.
  always_comb begin
    accept   = s_axis_tvalid && s_axis_tready;
    sel_sw   = s_axis_tuser ? s_width    : cfg_sw;
    sel_left = s_axis_tuser ? win_left   : cfg_left;
    sel_wid  = s_axis_tuser ? win_width  : cfg_wid;
    sel_sh   = s_axis_tuser ? s_height   : cfg_sh;
    sel_top  = s_axis_tuser ? win_top    : cfg_top;
    sel_hgt  = s_axis_tuser ? win_height : cfg_hgt;
    cur_col  = s_axis_tuser ? '0 : col;
    cur_row  = s_axis_tuser ? '0 : row;

    win_ok = (sel_wid != '0) && (sel_hgt != '0) && (sel_left <= sel_sw) && (sel_top <= sel_sh);

    avail_w = {1'b0, sel_sw} + WX'(1) - {1'b0, sel_left};
    effw    = ({1'b0, sel_wid} < avail_w) ? {1'b0, sel_wid} : avail_w;
    col_end = {1'b0, sel_left} + effw;
    avail_h = {1'b0, sel_sh} + HX'(1) - {1'b0, sel_top};
    effh    = ({1'b0, sel_hgt} < avail_h) ? {1'b0, sel_hgt} : avail_h;
    row_end = {1'b0, sel_top} + effh;

    in_win = (cur_col >= sel_left) && ({1'b0, cur_col} < col_end) &&
             (cur_row >= sel_top)  && ({1'b0, cur_row} < row_end);
    live      = s_axis_tuser ? win_ok : (state == ST_ACTIVE);
    keep      = accept && live && in_win;
    beat_last = ({1'b0, cur_col} == col_end - WX'(1));

    nxt_col = s_axis_tlast ? '0 : ((&cur_col) ? cur_col : cur_col + C_WIDTH_BITS'(1));
    nxt_row = s_axis_tlast ? ((&cur_row) ? cur_row : cur_row + C_HEIGHT_BITS'(1)) : cur_row;

    in_beat.dat  = s_axis_tdata;
    in_beat.user = s_axis_tuser || sof_pend;
    in_beat.last = beat_last;

    pop     = m_axis_tvalid && m_axis_tready;
    occ     = {1'b0, m_axis_tvalid} + {1'b0, sk_vld};
    occ_nxt = occ;
    if (keep && !pop)
      occ_nxt = occ + 2'd1;
    else if (!keep && pop)
      occ_nxt = occ - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      col           <= '0;
      row           <= '0;
      cfg_sw        <= '0;
      cfg_left      <= '0;
      cfg_wid       <= '0;
      cfg_sh        <= '0;
      cfg_top       <= '0;
      cfg_hgt       <= '0;
      sof_pend      <= 1'b0;
      sk_vld        <= 1'b0;
      sk_beat       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      s_axis_tready <= 1'b0;
      m_width       <= '0;
      m_height      <= '0;
    end else begin
      if (accept) begin
        col <= nxt_col;
        row <= nxt_row;
        if (s_axis_tuser) begin
          cfg_sw   <= s_width;
          cfg_left <= win_left;
          cfg_wid  <= win_width;
          cfg_sh   <= s_height;
          cfg_top  <= win_top;
          cfg_hgt  <= win_height;
          state    <= win_ok ? ST_ACTIVE : ST_DROP;
          if (win_ok) begin
            m_width  <= C_WIDTH_BITS'(effw - WX'(1));
            m_height <= C_HEIGHT_BITS'(effh - HX'(1));
          end
        end
        if (keep)
          sof_pend <= 1'b0;
        else if (s_axis_tuser)
          sof_pend <= 1'b1;
      end

      // Head of the skid is the output register itself, so data only moves on pop or into an empty head.
      if (pop) begin
        if (sk_vld) begin
          {m_axis_tdata, m_axis_tuser, m_axis_tlast} <= sk_beat;
          if (keep)
            sk_beat <= in_beat;
          else
            sk_vld <= 1'b0;
        end else if (keep) begin
          {m_axis_tdata, m_axis_tuser, m_axis_tlast} <= in_beat;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (keep) begin
        if (!m_axis_tvalid) begin
          {m_axis_tdata, m_axis_tuser, m_axis_tlast} <= in_beat;
          m_axis_tvalid <= 1'b1;
        end else begin
          sk_beat <= in_beat;
          sk_vld  <= 1'b1;
        end
      end

      s_axis_tready <= (occ_nxt != 2'd2);
    end
  end

endmodule

// File: tb/tb_axis_cropper.sv
// Randomised bench for axis_cropper: frame-level crop model feeding an expected-beat queue, checked every cycle.
module tb_axis_cropper;
  logic        clk = 1'b0;
  logic        resetn;
  logic        s_axis_tvalid, s_axis_tuser, s_axis_tlast, s_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic [11:0] s_width, win_left, win_width, m_width;
  logic [11:0] s_height, win_top, win_height, m_height;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tready;
  logic [7:0]  m_axis_tdata;

  always #5 clk = ~clk;

  axis_cropper dut (
    .clk(clk), .resetn(resetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .s_width(s_width), .s_height(s_height),
    .win_left(win_left), .win_width(win_width), .win_top(win_top), .win_height(win_height),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .m_width(m_width), .m_height(m_height)
  );

  int         checks = 0, errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] rx_log[$];
  int         acc_kept = 0, popped = 0;
  bit         hold_v = 0, last_acc = 0;
  logic [9:0] held;
  int         bp_mode = 0;
  int         exp_mw = 0, exp_mh = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // One clock cycle: compare outputs at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic [9:0] got;
    @(negedge clk);
    if (!resetn) begin
      exp_q.delete();
      popped = acc_kept;
      hold_v = 0;
    end else begin
      if (acc_kept - popped >= 2) chk("ready_when_full", int'(s_axis_tready), 0);
      got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (hold_v) chk("stable_while_stalled", int'(got), int'(held));
      if (m_axis_tvalid && m_axis_tready) begin
        popped++;
        rx_log.push_back(got);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected none", got);
        end else begin
          chk("beat", int'(got), int'(exp_q.pop_front()));
        end
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      held   = got;
    end
    last_acc = s_axis_tvalid && s_axis_tready;
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ($urandom_range(0, 99) >= 30);
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  task automatic drive_beat(input logic [7:0] dat, input bit user, input bit last, input bit kept, input bit gap);
    int n;
    while (gap && $urandom_range(0, 99) < 30) begin
      s_axis_tvalid = 1'b0;
      tick();
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = dat;
    s_axis_tuser  = user;
    s_axis_tlast  = last;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 2000);
    s_axis_tvalid = 1'b0;
    if (!last_acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept in %0d cycles expected accept", n);
      finish_run();
    end
    if (kept) acc_kept++;
  endtask

  // Model: walk the frame in raster order and keep what falls inside the clamped window.
  task automatic send_frame(input int sw, input int sh, input int l, input int w, input int t, input int h,
                            input int seed, input int npix, input bit sof, input bit gap);
    bit ok, first, kept, lst;
    int effw, effh, n;
    logic [7:0] dat;
    ok   = sof && w > 0 && h > 0 && l <= sw && t <= sh;
    effw = (w < sw + 1 - l) ? w : sw + 1 - l;
    effh = (h < sh + 1 - t) ? h : sh + 1 - t;
    if (ok) begin
      exp_mw = effw - 1;
      exp_mh = effh - 1;
    end
    s_width = 12'(sw); s_height = 12'(sh);
    win_left = 12'(l); win_width = 12'(w); win_top = 12'(t); win_height = 12'(h);
    first = 1;
    n = 0;
    for (int r = 0; r <= sh && n < npix; r++) begin
      for (int c = 0; c <= sw && n < npix; c++) begin
        kept = ok && c >= l && c < l + effw && r >= t && r < t + effh;
        lst  = (c == l + effw - 1);
        dat  = 8'((seed + r * (sw + 1) + c) % 256);
        if (kept) begin
          exp_q.push_back({first, lst, dat});
          first = 0;
        end
        drive_beat(dat, sof && n == 0, c == sw, kept, gap);
        n++;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats still pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tvalid"}, int'(m_axis_tvalid), 0);
    chk({tag, "_tdata"},  int'(m_axis_tdata), 0);
    chk({tag, "_tuser"},  int'(m_axis_tuser), 0);
    chk({tag, "_tlast"},  int'(m_axis_tlast), 0);
    chk({tag, "_sready"}, int'(s_axis_tready), 0);
    chk({tag, "_mwidth"}, int'(m_width), 0);
    chk({tag, "_mheight"}, int'(m_height), 0);
  endtask

  int lasts;
  int exp21[6] = '{'h20A, 'h00B, 'h10C, 'h012, 'h013, 'h114};

  initial begin
    resetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    s_width = '0; s_height = '0; win_left = '0; win_width = '0; win_top = '0; win_height = '0;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    check_zero_outputs("reset");
    resetn = 1'b1;
    tick();
    chk("ready_after_reset", int'(s_axis_tready), 1);

    // Full pass
    rx_log.delete();
    send_frame(7, 3, 0, 8, 0, 4, 0, 32, 1, 0);
    drain();
    chk("full_count", rx_log.size(), 32);
    chk("full_user0", int'(rx_log[0][9]), 1);
    lasts = 0;
    foreach (rx_log[i]) lasts += int'(rx_log[i][8]);
    chk("full_last_count", lasts, 4);
    chk("full_last7", int'(rx_log[7][8]), 1);
    chk("full_last31", int'(rx_log[31][8]), 1);
    chk("full_data20", int'(rx_log[20][7:0]), 20);
    chk("full_mwidth", int'(m_width), 7);
    chk("full_mheight", int'(m_height), 3);

    // Interior crop
    rx_log.delete();
    send_frame(7, 3, 2, 3, 1, 2, 0, 32, 1, 0);
    drain();
    chk("interior_count", rx_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("interior_beat", int'(rx_log[i]), exp21[i]);
    chk("interior_mwidth", int'(m_width), 2);
    chk("interior_mheight", int'(m_height), 1);

    // Clamped width, then an invalid window
    rx_log.delete();
    send_frame(7, 3, 6, 5, 0, 4, 40, 32, 1, 1);
    drain();
    chk("clamp_count", rx_log.size(), 8);
    chk("clamp_mwidth", int'(m_width), 1);
    rx_log.delete();
    send_frame(7, 3, 0, 8, 4, 2, 7, 32, 1, 0);
    drain();
    chk("invalid_count", rx_log.size(), 0);
    chk("invalid_mwidth", int'(m_width), 1);
    chk("invalid_mheight", int'(m_height), 3);

    // Backpressure with input gaps
    rx_log.delete();
    bp_mode = 1;
    send_frame(7, 3, 0, 8, 0, 4, 0, 32, 1, 1);
    drain();
    chk("bp_count", rx_log.size(), 32);
    chk("bp_data31", int'(rx_log[31]), 'h11F);

    // Early tuser after 13 pixels
    rx_log.delete();
    send_frame(7, 3, 0, 8, 0, 4, 100, 13, 1, 1);
    send_frame(7, 3, 2, 3, 1, 2, 0, 32, 1, 1);
    drain();
    chk("early_count", rx_log.size(), 19);
    chk("early_first", int'(rx_log[0]), 'h264);
    chk("early_trunc", int'(rx_log[12]), 'h070);
    chk("early_newsof", int'(rx_log[13]), 'h20A);
    chk("early_mwidth", int'(m_width), 2);
    bp_mode = 0;
    tick();

    // Reset with beats buffered in the skid
    bp_mode = 2;
    send_frame(7, 3, 0, 8, 0, 4, 0, 2, 1, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    exp_mw = 0;
    exp_mh = 0;
    check_zero_outputs("midreset");
    bp_mode = 0;
    tick();
    chk("midreset_ready", int'(s_axis_tready), 1);
    rx_log.delete();
    send_frame(7, 3, 0, 8, 0, 4, 3, 20, 0, 0);
    drain();
    chk("no_sof_count", rx_log.size(), 0);
    send_frame(7, 3, 0, 8, 0, 4, 9, 32, 1, 0);
    drain();
    chk("resume_count", rx_log.size(), 32);

    // Randomised frames
    for (int f = 0; f < 25; f++) begin
      int sw, sh, total, npix;
      sw = $urandom_range(0, 9);
      sh = $urandom_range(0, 5);
      total = (sw + 1) * (sh + 1);
      npix = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total) : total;
      bp_mode = $urandom_range(0, 1);
      send_frame(sw, sh, $urandom_range(0, sw + 1), $urandom_range(0, sw + 2),
                 $urandom_range(0, sh + 1), $urandom_range(0, sh + 2),
                 $urandom_range(0, 255), npix, 1, $urandom_range(0, 1) == 1);
      drain();
      chk("rand_mwidth", int'(m_width), exp_mw);
      chk("rand_mheight", int'(m_height), exp_mh);
    end

    finish_run();
  end
endmodule
